// File: rtl/sd_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// sd_cmd_arbiter
//
// Purpose:
//    Shares one SD command engine between two requesters (req0 = card-init
//    sequencer, req1 = data-transfer controller). A round-robin arbiter grants
//    one request at a time, latches its command fields, pulses the engine
//    start, and runs a response watchdog. The captured response and status go
//    back to the owning requester. A programmable idle gap is then inserted
//    before the next grant so the CMD line sees the required NCC spacing.
//
// Parameters:
//    TIMEOUT_CYCLES  clk_i cycles spent in WAIT before the command is aborted
//    GAP_CYCLES      idle cycles between the response pulse and the next grant
//                    (0 = no gap)
//
// Ports:
//    clk_i, rst_i                 clock, asynchronous active-high reset
//    reqN_valid_i/ready_o         request handshake (ready is combinational)
//    reqN_idx_i/arg_i/rtype_i     command fields, held with valid
//    rspN_valid_o                 one-cycle response pulse to requester N
//    rsp_status_o, rsp_data_o     registered status/payload, held until next
//    eng_start_o, eng_abort_o     one-cycle pulses to the command engine
//    eng_idx_o/arg_o/rtype_o      latched command fields for the engine
//    eng_done_i, eng_crc_err_i,
//    eng_noresp_i, eng_resp_i     engine completion and its qualified status
//    busy_o                       arbiter not idle
// -----------------------------------------------------------------------------
module sd_cmd_arbiter #(
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int GAP_CYCLES     = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [5:0]  req0_idx_i,
   input  logic [31:0] req0_arg_i,
   input  logic [1:0]  req0_rtype_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [5:0]  req1_idx_i,
   input  logic [31:0] req1_arg_i,
   input  logic [1:0]  req1_rtype_i,
   output logic        rsp0_valid_o,
   output logic        rsp1_valid_o,
   output logic [1:0]  rsp_status_o,
   output logic [31:0] rsp_data_o,
   output logic        eng_start_o,
   output logic [5:0]  eng_idx_o,
   output logic [31:0] eng_arg_o,
   output logic [1:0]  eng_rtype_o,
   output logic        eng_abort_o,
   input  logic        eng_done_i,
   input  logic        eng_crc_err_i,
   input  logic        eng_noresp_i,
   input  logic [31:0] eng_resp_i,
   output logic        busy_o
);

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GP_W-1:0] GP_LOAD  = GP_W'(GAP_CYCLES);
   localparam bit              HAS_GAP  = (GAP_CYCLES > 0);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_CRC     = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_NORESP  = 2'b11;
   localparam logic [1:0] RT_R3      = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_last_grant;
   logic              r_owner;
   logic [5:0]        r_idx;
   logic [31:0]       r_arg;
   logic [1:0]        r_rtype;
   logic [WD_W-1:0]   r_wd;
   logic [GP_W-1:0]   r_gap;
   logic [1:0]        r_status;
   logic [31:0]       r_data;

   logic              w_grant0;
   logic              w_grant1;
   logic              w_expire;
   logic              w_finish;
   logic [1:0]        w_status;
   logic              w_start;
   logic              w_rsp0;
   logic              w_rsp1;
   logic              w_busy;

   // Round-robin grant: a tie goes to the requester that did not win last.
   // Ready is suppressed while reset is held so no handshake completes then.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if ((r_state == S_IDLE) && !rst_i) begin
         if (req0_valid_i && req1_valid_i) begin
            if (r_last_grant) begin
               w_grant0 = 1'b1;
            end else begin
               w_grant1 = 1'b1;
            end
         end else if (req0_valid_i) begin
            w_grant0 = 1'b1;
         end else if (req1_valid_i) begin
            w_grant1 = 1'b1;
         end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
         end
      end else begin
         w_grant0 = 1'b0;
         w_grant1 = 1'b0;
      end
   end

   // Completion decode in WAIT: a done in the expiry cycle beats the watchdog.
   always_comb begin
      w_expire = 1'b0;
      w_finish = 1'b0;
      w_status = ST_OK;
      if (r_state == S_WAIT) begin
         w_expire = !eng_done_i && (r_wd == WD_LAST);
         w_finish = eng_done_i || w_expire;
      end else begin
         w_expire = 1'b0;
         w_finish = 1'b0;
      end
      if (!eng_done_i) begin
         w_status = ST_TIMEOUT;
      end else if (eng_noresp_i) begin
         w_status = ST_NORESP;
      end else if (eng_crc_err_i && (r_rtype != RT_R3)) begin
         // R3 carries no valid CRC, so the engine's CRC flag is meaningless
         w_status = ST_CRC;
      end else begin
         w_status = ST_OK;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant0 || w_grant1) begin
               w_next_state = S_ISSUE;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_ISSUE: begin
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (w_finish) begin
               w_next_state = S_RESP;
            end else begin
               w_next_state = S_WAIT;
            end
         end
         S_RESP: begin
            if (HAS_GAP) begin
               w_next_state = S_GAP;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_GAP: begin
            // the decrement that brings the counter to zero also leaves GAP
            if (r_gap <= GP_W'(1)) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_GAP;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // FSM output decode (all driven from the registered state).
   always_comb begin
      w_start = 1'b0;
      w_rsp0  = 1'b0;
      w_rsp1  = 1'b0;
      w_busy  = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
         end
         S_ISSUE: begin
            w_start = 1'b1;
         end
         S_WAIT: begin
            w_start = 1'b0;
         end
         S_RESP: begin
            w_rsp0 = !r_owner;
            w_rsp1 = r_owner;
         end
         S_GAP: begin
            w_start = 1'b0;
         end
         default: begin
            w_busy = 1'b1;
         end
      endcase
   end

   // Grant bookkeeping and command field latches; fields only change on a
   // grant so they stay stable from ISSUE through RESP.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_idx        <= 6'd0;
         r_arg        <= 32'd0;
         r_rtype      <= 2'b00;
      end else if (w_grant0) begin
         r_last_grant <= 1'b0;
         r_owner      <= 1'b0;
         r_idx        <= req0_idx_i;
         r_arg        <= req0_arg_i;
         r_rtype      <= req0_rtype_i;
      end else if (w_grant1) begin
         r_last_grant <= 1'b1;
         r_owner      <= 1'b1;
         r_idx        <= req1_idx_i;
         r_arg        <= req1_arg_i;
         r_rtype      <= req1_rtype_i;
      end else begin
         r_last_grant <= r_last_grant;
         r_owner      <= r_owner;
         r_idx        <= r_idx;
         r_arg        <= r_arg;
         r_rtype      <= r_rtype;
      end
   end

   // Response watchdog: cleared on issue, counts every WAIT cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wd <= '0;
      end else if (r_state == S_ISSUE) begin
         r_wd <= '0;
      end else if (r_state == S_WAIT) begin
         r_wd <= r_wd + WD_W'(1);
      end else begin
         r_wd <= r_wd;
      end
   end

   // Response capture; held until the next command completes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_status <= ST_OK;
         r_data   <= 32'd0;
      end else if (w_finish) begin
         r_status <= w_status;
         r_data   <= eng_done_i ? eng_resp_i : 32'd0;
      end else begin
         r_status <= r_status;
         r_data   <= r_data;
      end
   end

   // Inter-command gap counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_gap <= '0;
      end else if (r_state == S_RESP) begin
         r_gap <= GP_LOAD;
      end else if ((r_state == S_GAP) && (r_gap != '0)) begin
         r_gap <= r_gap - GP_W'(1);
      end else begin
         r_gap <= r_gap;
      end
   end

   assign req0_ready_o = w_grant0;
   assign req1_ready_o = w_grant1;
   assign rsp0_valid_o = w_rsp0;
   assign rsp1_valid_o = w_rsp1;
   assign rsp_status_o = r_status;
   assign rsp_data_o   = r_data;
   assign eng_start_o  = w_start;
   assign eng_idx_o    = r_idx;
   assign eng_arg_o    = r_arg;
   assign eng_rtype_o  = r_rtype;
   assign eng_abort_o  = w_expire;
   assign busy_o       = w_busy;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
module tb_sd_cmd_arbiter;

   localparam int T   = 64;
   localparam int G   = 16;
   localparam int BIG = 32'h7fff_ffff;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req0_valid_i, req1_valid_i;
   logic        req0_ready_o, req1_ready_o;
   logic [5:0]  req0_idx_i, req1_idx_i;
   logic [31:0] req0_arg_i, req1_arg_i;
   logic [1:0]  req0_rtype_i, req1_rtype_i;
   logic        rsp0_valid_o, rsp1_valid_o;
   logic [1:0]  rsp_status_o;
   logic [31:0] rsp_data_o;
   logic        eng_start_o, eng_abort_o;
   logic [5:0]  eng_idx_o;
   logic [31:0] eng_arg_o;
   logic [1:0]  eng_rtype_o;
   logic        eng_done_i, eng_crc_err_i, eng_noresp_i;
   logic [31:0] eng_resp_i;
   logic        busy_o;

   always #5 clk = ~clk;

   sd_cmd_arbiter #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
      .req0_idx_i(req0_idx_i), .req0_arg_i(req0_arg_i), .req0_rtype_i(req0_rtype_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
      .req1_idx_i(req1_idx_i), .req1_arg_i(req1_arg_i), .req1_rtype_i(req1_rtype_i),
      .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o),
      .rsp_status_o(rsp_status_o), .rsp_data_o(rsp_data_o),
      .eng_start_o(eng_start_o), .eng_idx_o(eng_idx_o), .eng_arg_o(eng_arg_o),
      .eng_rtype_o(eng_rtype_o), .eng_abort_o(eng_abort_o),
      .eng_done_i(eng_done_i), .eng_crc_err_i(eng_crc_err_i),
      .eng_noresp_i(eng_noresp_i), .eng_resp_i(eng_resp_i), .busy_o(busy_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // requester drivers
   bit          dv [2];
   logic [5:0]  didx [2];
   logic [31:0] darg [2];
   logic [1:0]  drt [2];
   // engine driver
   bit          rand_mode = 1'b0;
   bit          spur_en = 1'b0;
   bit          force_spur = 1'b0;
   int          dir_k = 5;
   bit          dir_crc = 1'b0, dir_nr = 1'b0;
   logic [31:0] dir_resp = 32'd0;
   int          sched_done = -1;
   bit          s_crc, s_nr;
   logic [31:0] s_resp;

   // transaction-level reference: everything is timestamps in cycles
   int          cyc = 0;
   int          idle_at = 0;   // first cycle the arbiter may grant again
   bit          has_txn = 1'b0;
   int          g = 0;         // grant cycle of the current command
   int          r = -1;        // cycle of its response pulse (-1 = pending)
   bit          m_owner = 1'b0, m_last = 1'b1;
   logic [5:0]  m_idx = 6'd0;
   logic [31:0] m_arg = 32'd0;
   logic [1:0]  m_rtype = 2'b00;
   logic [1:0]  m_status = 2'b00, p_status = 2'b00;
   logic [31:0] m_data = 32'd0, p_data = 32'd0;

   // observed DUT events, for the hand-computed checks
   int obs_ready = -1, obs_start = -1, obs_rsp = -1, obs_abort = -1;
   int n_rsp = 0, n_abort = 0;
   int grant_log [$];
   int gap_log [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [1:0] exp_status(input bit nr, input bit crc, input logic [1:0] rt);
      if (nr) return 2'b11;
      if (crc && rt != 2'b11) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      idle_at = cyc; has_txn = 1'b0; r = -1; m_last = 1'b1; m_owner = 1'b0;
      m_idx = 6'd0; m_arg = 32'd0; m_rtype = 2'b00; m_status = 2'b00; m_data = 32'd0;
      sched_done = -1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready0"}, req0_ready_o, 1'b0);
      chk({tag, "_ready1"}, req1_ready_o, 1'b0);
      chk({tag, "_rsp0"}, rsp0_valid_o, 1'b0);
      chk({tag, "_rsp1"}, rsp1_valid_o, 1'b0);
      chk({tag, "_start"}, eng_start_o, 1'b0);
      chk({tag, "_abort"}, eng_abort_o, 1'b0);
      chk({tag, "_busy"}, busy_o, 1'b0);
      chk({tag, "_status"}, rsp_status_o, 2'b00);
      chk({tag, "_data"}, rsp_data_o, 32'd0);
      chk({tag, "_idx"}, eng_idx_o, 6'd0);
      chk({tag, "_arg"}, eng_arg_o, 32'd0);
      chk({tag, "_rtype"}, eng_rtype_o, 2'b00);
   endtask

   // One clock cycle: drive inputs, predict, compare every output.
   task automatic step();
      bit in_wait, idle, e_start, e_abort, e_rsp0, e_rsp1;
      int win, k, sel;
      @(negedge clk);
      in_wait = has_txn && (r < 0) && (cyc >= g + 2);
      if (rand_mode) begin
         for (int n = 0; n < 2; n++) begin
            if (!dv[n]) begin
               if ($urandom_range(0, 3) == 0) begin
                  dv[n] = 1'b1; didx[n] = 6'($urandom); darg[n] = $urandom; drt[n] = 2'($urandom);
               end
            end else if ($urandom_range(0, 39) == 0) begin
               dv[n] = 1'b0;
            end
         end
      end
      req0_valid_i = dv[0]; req0_idx_i = didx[0]; req0_arg_i = darg[0]; req0_rtype_i = drt[0];
      req1_valid_i = dv[1]; req1_idx_i = didx[1]; req1_arg_i = darg[1]; req1_rtype_i = drt[1];
      if (cyc == sched_done) begin
         eng_done_i = 1'b1; eng_crc_err_i = s_crc; eng_noresp_i = s_nr; eng_resp_i = s_resp;
      end else begin
         eng_done_i = !in_wait && (force_spur || (spur_en && $urandom_range(0, 19) == 0));
         eng_crc_err_i = 1'($urandom); eng_noresp_i = 1'($urandom); eng_resp_i = $urandom;
      end
      force_spur = 1'b0;
      #1;
      idle = (cyc >= idle_at);
      win = -1;
      if (idle) begin
         if (dv[0] && dv[1]) win = m_last ? 0 : 1;
         else if (dv[0]) win = 0;
         else if (dv[1]) win = 1;
      end
      e_start = has_txn && (cyc == g + 1);
      e_abort = 1'b0;
      if (in_wait) begin
         if (eng_done_i) begin
            p_status = exp_status(eng_noresp_i, eng_crc_err_i, m_rtype);
            p_data = eng_resp_i; r = cyc + 1; idle_at = r + G + 1;
         end else if (cyc == g + 1 + T) begin
            e_abort = 1'b1; p_status = 2'b10; p_data = 32'd0; r = cyc + 1; idle_at = r + G + 1;
         end
      end
      if (has_txn && cyc == r) begin
         m_status = p_status; m_data = p_data;
      end
      e_rsp0 = has_txn && (cyc == r) && !m_owner;
      e_rsp1 = has_txn && (cyc == r) && m_owner;
      chk("ready0", req0_ready_o, win == 0);
      chk("ready1", req1_ready_o, win == 1);
      chk("start", eng_start_o, e_start);
      chk("abort", eng_abort_o, e_abort);
      chk("rsp0", rsp0_valid_o, e_rsp0);
      chk("rsp1", rsp1_valid_o, e_rsp1);
      chk("status", rsp_status_o, m_status);
      chk("data", rsp_data_o, m_data);
      chk("eng_idx", eng_idx_o, m_idx);
      chk("eng_arg", eng_arg_o, m_arg);
      chk("eng_rtype", eng_rtype_o, m_rtype);
      chk("busy", busy_o, !idle);
      if (req0_ready_o || req1_ready_o) begin
         if (obs_rsp >= 0) gap_log.push_back(cyc - obs_rsp);
         grant_log.push_back(req1_ready_o ? 1 : 0);
         obs_ready = cyc;
      end
      if (eng_start_o) obs_start = cyc;
      if (eng_abort_o) begin obs_abort = cyc; n_abort++; end
      if (rsp0_valid_o || rsp1_valid_o) begin obs_rsp = cyc; n_rsp++; end
      if (win >= 0) begin
         m_owner = win[0]; m_last = win[0];
         m_idx = didx[win]; m_arg = darg[win]; m_rtype = drt[win];
         has_txn = 1'b1; g = cyc; r = -1; idle_at = BIG;
         if (rand_mode) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) k = -1;
            else if (sel == 1) k = T;
            else if (sel < 6) k = $urandom_range(1, 10);
            else k = $urandom_range(1, T - 1);
            s_crc = 1'($urandom); s_nr = ($urandom_range(0, 3) == 0); s_resp = $urandom;
         end else begin
            k = dir_k; s_crc = dir_crc; s_nr = dir_nr; s_resp = dir_resp;
         end
         sched_done = (k < 0) ? -1 : cyc + 1 + k;
         dv[win] = 1'b0;
      end
      cyc++;
   endtask

   task automatic wait_rsp(input int bound);
      int n0 = n_rsp;
      int i = 0;
      while (n_rsp == n0 && i < bound) begin step(); i++; end
      if (n_rsp == n0) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_rsp: no response within %0d cycles", bound);
      end
   endtask

   task automatic run_idle(input int bound);
      int i = 0;
      while (cyc < idle_at && i < bound) begin step(); i++; end
      if (cyc < idle_at) begin
         n_cmp++; n_bad++;
         $display("FAIL run_idle: arbiter not idle within %0d cycles", bound);
      end
   endtask

   task automatic do_txn(input int n, input logic [1:0] rt, input int k,
                         input bit crc, input bit nr, input logic [31:0] resp);
      dv[n] = 1'b1; didx[n] = 6'(n + 10); darg[n] = 32'h1234_0000 + n; drt[n] = rt;
      dir_k = k; dir_crc = crc; dir_nr = nr; dir_resp = resp;
      wait_rsp(T + 40);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int n0, a0;
      for (int n = 0; n < 2; n++) begin dv[n] = 1'b0; didx[n] = 6'd0; darg[n] = 32'd0; drt[n] = 2'b00; end
      rst_i = 1'b1;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      req0_idx_i = 6'd0; req0_arg_i = 32'd0; req0_rtype_i = 2'b00;
      req1_idx_i = 6'd0; req1_arg_i = 32'd0; req1_rtype_i = 2'b00;
      eng_done_i = 1'b0; eng_crc_err_i = 1'b0; eng_noresp_i = 1'b0; eng_resp_i = 32'd0;
      #1;
      chk_zero("reset");
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      model_reset();

      // tie, back to back, twice: grants alternate starting with req0
      dir_k = 5; dir_crc = 1'b0; dir_nr = 1'b0; dir_resp = 32'h0000_0055;
      didx[0] = 6'd2; darg[0] = 32'h0; drt[0] = 2'b10;
      didx[1] = 6'd17; darg[1] = 32'h200; drt[1] = 2'b01;
      begin
         int i = 0;
         while (grant_log.size() < 4 && i < 400) begin
            dv[0] = 1'b1; dv[1] = 1'b1; step(); i++;
         end
      end
      dv[0] = 1'b0; dv[1] = 1'b0;
      chk("tie_grant_count", grant_log.size(), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("tie_order", grant_log[i], i % 2);
      for (int i = 0; i < gap_log.size(); i++) chk("gap_min", gap_log[i] >= G, 1'b1);
      run_idle(300);

      // single req0, CMD8, response after 40 cycles
      didx[0] = 6'd8; darg[0] = 32'h0000_01AA; drt[0] = 2'b01; dv[0] = 1'b1;
      dir_k = 40; dir_crc = 1'b0; dir_nr = 1'b0; dir_resp = 32'h0000_01AA;
      wait_rsp(200);
      chk("t1_start_lat", obs_start - obs_ready, 1);
      chk("t1_rsp_lat", obs_rsp - obs_ready, 42);
      chk("t1_status", rsp_status_o, 2'b00);
      chk("t1_data", rsp_data_o, 32'h0000_01AA);
      run_idle(100);

      // watchdog expiry
      a0 = n_abort;
      do_txn(0, 2'b01, -1, 1'b0, 1'b0, 32'hFFFF_FFFF);
      chk("t3_abort_seen", n_abort - a0, 1);
      chk("t3_abort_lat", obs_abort - obs_start, 64);
      chk("t3_rsp_after_abort", obs_rsp - obs_abort, 1);
      chk("t3_status", rsp_status_o, 2'b10);
      chk("t3_data", rsp_data_o, 32'd0);
      run_idle(100);

      // status priority and R3 CRC masking
      do_txn(1, 2'b01, 7, 1'b1, 1'b0, 32'h0000_0A0A);
      chk("t4_crc_r1", rsp_status_o, 2'b01);
      run_idle(100);
      do_txn(0, 2'b11, 7, 1'b1, 1'b0, 32'h00FF_8000);
      chk("t4_crc_r3", rsp_status_o, 2'b00);
      chk("t4_crc_r3_data", rsp_data_o, 32'h00FF_8000);
      run_idle(100);
      do_txn(1, 2'b01, 7, 1'b1, 1'b1, 32'h0000_0B0B);
      chk("t4_noresp", rsp_status_o, 2'b11);
      run_idle(100);

      // done in the exact expiry cycle, then a spurious done while idle
      a0 = n_abort;
      do_txn(0, 2'b01, T, 1'b0, 1'b0, 32'hDEAD_BEEF);
      chk("t5_no_abort", n_abort - a0, 0);
      chk("t5_rsp_lat", obs_rsp - obs_start, T + 1);
      chk("t5_status", rsp_status_o, 2'b00);
      chk("t5_data", rsp_data_o, 32'hDEAD_BEEF);
      run_idle(100);
      n0 = n_rsp;
      force_spur = 1'b1;
      repeat (4) step();
      chk("t5_spurious_rsp", n_rsp - n0, 0);

      // reset in the middle of WAIT
      dv[0] = 1'b1; didx[0] = 6'd55; darg[0] = 32'h0; drt[0] = 2'b01; dir_k = -1;
      begin
         int i = 0;
         while (!(has_txn && r < 0 && cyc >= g + 12) && i < 100) begin step(); i++; end
      end
      chk("t6_in_wait", busy_o, 1'b1);
      n0 = n_rsp;
      @(negedge clk);
      req0_valid_i = 1'b1; req1_valid_i = 1'b1; eng_done_i = 1'b0;
      rst_i = 1'b1;
      #1;
      chk_zero("t6_rst");
      repeat (2) begin @(negedge clk); #1; chk_zero("t6_rst_hold"); end
      @(negedge clk);
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      rst_i = 1'b0;
      model_reset();
      chk("t6_no_rsp", n_rsp - n0, 0);
      grant_log.delete();
      dv[0] = 1'b1; dv[1] = 1'b1; didx[1] = 6'd3; darg[1] = 32'h3; drt[1] = 2'b10;
      dir_k = 3; dir_resp = 32'h1357_9BDF;
      step();
      chk("t6_tie_after_rst", grant_log.size() > 0 ? grant_log[0] : -1, 0);
      dv[1] = 1'b0;
      wait_rsp(100);
      run_idle(100);

      // randomized traffic against the timestamp model
      rand_mode = 1'b1; spur_en = 1'b1;
      repeat (4000) step();
      rand_mode = 1'b0; spur_en = 1'b0;
      dv[0] = 1'b0; dv[1] = 1'b0;
      run_idle(T + G + 20);
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
